// File: rtl/invader_fleet.sv
// invader_fleet: marching invader grid with bullet collision, edge-aware
// fleet stepping, landing and wave-cleared detection.
// Optional macro INVADER_SPEEDUP_EN halves the step period once eight or
// fewer invaders remain.
module invader_fleet #(
  parameter int COLS        = 8,
  parameter int ROWS        = 4,
  parameter int STEP_PERIOD = 16,
  parameter int SHIP_ROW    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [4:0]           bulletX,
  input  logic [3:0]           bulletY,
  input  logic                 bulletActive,
  output logic                 hit,
  output logic [COLS*ROWS-1:0] alive,
  output logic [4:0]           originX,
  output logic [3:0]           originY,
  output logic                 waveCleared,
  output logic                 landed
);

  localparam int N = COLS * ROWS;

  typedef enum logic [1:0] {RUN, LANDED, CLEARED} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   alive_q, alive_d;
  logic [4:0]     origin_x_q, origin_x_d;
  logic [3:0]     origin_y_q, origin_y_d;
  logic           dir_left_q, dir_left_d;
  logic [7:0]     step_cnt_q, step_cnt_d;
  logic           hit_q, hit_d;

  logic [COLS-1:0] col_any;
  logic [5:0]      max_col, min_col;
  logic [7:0]      period;

  // Column occupancy: a column counts while any of its invaders lives.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic [ROWS-1:0] bits;
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      assign bits[gr] = alive_q[gr*COLS+gi];
    end
    assign col_any[gi] = |bits;
  end

  // Outermost living columns bound how far the fleet may march.
  always_comb begin
    max_col = 6'd0;
    min_col = 6'd0;
    for (int c = 0; c < COLS; c++)
      if (col_any[c]) max_col = 6'(c);
    for (int c = COLS - 1; c >= 0; c--)
      if (col_any[c]) min_col = 6'(c);
  end

`ifdef INVADER_SPEEDUP_EN
  localparam int HALF_PERIOD = (STEP_PERIOD / 2 < 1) ? 1 : STEP_PERIOD / 2;
  int alive_count;

  // Thin fleets march at double pace.
  always_comb begin
    alive_count = 0;
    for (int i = 0; i < N; i++)
      if (alive_q[i]) alive_count++;
    period = (alive_count <= 8) ? 8'(HALF_PERIOD) : 8'(STEP_PERIOD);
  end
`else
  assign period = 8'(STEP_PERIOD);
`endif

  logic [5:0] dx;
  logic [4:0] dy;
  logic       x_in, y_in;
  int         hit_idx;
  logic [4:0] max_row;

  // Next-state: collision, step pacing, fleet movement and end conditions.
  always_comb begin
    state_d    = state_q;
    alive_d    = alive_q;
    origin_x_d = origin_x_q;
    origin_y_d = origin_y_q;
    dir_left_d = dir_left_q;
    step_cnt_d = step_cnt_q;
    hit_d      = 1'b0;
    max_row    = 5'd0;

    dx      = {1'b0, bulletX} - {1'b0, origin_x_q};
    dy      = {1'b0, bulletY} - {1'b0, origin_y_q};
    x_in    = (bulletX >= origin_x_q) && (dx < 6'(COLS));
    y_in    = (bulletY >= origin_y_q) && (dy < 5'(ROWS));
    hit_idx = (x_in && y_in) ? (int'(dy) * COLS + int'(dx)) : 0;

    if (state_q == RUN) begin
      // Collision uses the registered origin, so it composes with a step.
      if (bulletActive && x_in && y_in && alive_q[hit_idx]) begin
        alive_d[hit_idx] = 1'b0;
        hit_d            = 1'b1;
      end

      if (alive_q == '0) begin
        state_d = CLEARED;
      end else if (enable) begin
        // >= lets a counter stranded above a shortened period step at once.
        if (step_cnt_q >= 8'(period - 8'd1)) begin
          step_cnt_d = 8'd0;
          if (!dir_left_q) begin
            if ({1'b0, origin_x_q} + max_col < 6'd31) begin
              origin_x_d = origin_x_q + 5'd1;
            end else begin
              origin_y_d = origin_y_q + 4'd1;
              dir_left_d = 1'b1;
            end
          end else begin
            if ({1'b0, origin_x_q} + min_col > 6'd0) begin
              origin_x_d = origin_x_q - 5'd1;
            end else begin
              origin_y_d = origin_y_q + 4'd1;
              dir_left_d = 1'b0;
            end
          end
        end else begin
          step_cnt_d = step_cnt_q + 8'd1;
        end
      end

      // Landing is judged on the post-edge fleet so no extra step slips in.
      if (state_d == RUN && alive_d != '0) begin
        for (int r = 0; r < ROWS; r++)
          if (|alive_d[r*COLS +: COLS]) max_row = 5'(r);
        if ({1'b0, origin_y_d} + max_row >= 5'(SHIP_ROW))
          state_d = LANDED;
      end
    end
  end

  // State registers; reset and clear both restart the wave.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= RUN;
      alive_q    <= '1;
      origin_x_q <= 5'd0;
      origin_y_q <= 4'd0;
      dir_left_q <= 1'b0;
      step_cnt_q <= 8'd0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alive_q    <= alive_d;
      origin_x_q <= origin_x_d;
      origin_y_q <= origin_y_d;
      dir_left_q <= dir_left_d;
      step_cnt_q <= step_cnt_d;
      hit_q      <= hit_d;
    end
  end

  assign hit         = hit_q;
  assign alive       = alive_q;
  assign originX     = origin_x_q;
  assign originY     = origin_y_q;
  assign waveCleared = (state_q == CLEARED);
  assign landed      = (state_q == LANDED);

endmodule
